seg7_pattern_decoder: RTL
=========================

// Module: seg7_pattern_decoder
// PURPOSE
//  Inverse of the team's hex-to-7-segment encoder. Samples an external active-low 7-segment bus
//  (e.g. from a GPIO header) and requires each pattern to hold stable before decoding it back to
//  a 4-bit hex digit. Each decoded digit is presented on a valid/ready handshake and pushed into a
//  digit-history register for display/readback. Sits between GPIO pins and the board display logic.
// PARAMETERS
//  STABLE_CYCLES  16  consecutive identical samples needed before a pattern is decoded (>=2)
//  DEPTH          8   digits kept in history (1..8)
// PORTS
//  CLOCK_50   in   1          system clock, all logic on rising edge
//  RESET_N    in   1          asynchronous active-low reset
//  seg_n      in   7          active-low segments {g,f,e,d,c,b,a}; asynchronous, synchronized inside
//  sample_en  in   1          1 = capture active; 0 = FSM forced to IDLE (no new reports)
//  ready      in   1          consumer accepts digit when valid&&ready
//  valid      out  1          digit/invalid hold a stable, unaccepted result
//  digit      out  4          decoded hex value (0 when invalid)
//  invalid    out  1          pattern matched no table entry
//  history    out  4*DEPTH    accepted valid digits, newest in [3:0]
//  count      out  4          accepted valid digits since reset, saturates at 15
// BEHAVIOUR
//  - Reset: valid=0, digit=0, invalid=0, history=0, count=0, FSM=IDLE, sync flops=7'h7F (blank).
//  - seg_n passes a 2-flop synchronizer; internal pattern p = ~sync (1 = lit).
//  - Table (p -> digit): 3F:0 06:1 5B:2 4F:3 66:4 6D:5 7D:6 07:7 7F:8 67:9 77:A 7C:B 39:C 5E:D 79:E 71:F.
//  - Stability counter: resets to 1 on any change of p, increments while p unchanged, saturates.
//  - FSM states: IDLE, SETTLE, PRESENT, HOLD.
//    IDLE: p!=0 and sample_en -> SETTLE. p==0 (blank) never reported.
//    SETTLE: p changes -> counter restarts, stay; p==0 -> IDLE; counter==STABLE_CYCLES -> PRESENT,
//            same edge registers digit/invalid from p and sets valid=1 (latency: STABLE_CYCLES+2 clocks from pin).
//    PRESENT: valid, digit, invalid frozen regardless of p; on valid&&ready -> HOLD, valid=0 next clock.
//    HOLD: reported pattern is not re-reported; p differs from reported pattern -> SETTLE (p!=0) or IDLE (p==0).
//  - Transfer (valid&&ready) with invalid=0: history <= {history[4*DEPTH-5:0], digit}; count+1 unless 15.
//    Transfer with invalid=1: history/count unchanged.
//  - ready high while valid low: no effect. valid never drops without a transfer (except reset / sample_en=0).
//  - sample_en=0: next clock FSM=IDLE, valid=0, pending digit discarded; history/count retained.
//  - Reset mid-operation: all state returns to reset values immediately (asynchronous).
// CONFIGURATION
//  SEG7_ALT_GLYPH_EN defined: also accept alternate glyphs 6F -> 9 and 27 -> 7 (invalid=0).
//  Not defined: 6F and 27 decode as invalid=1, digit=0.
// TESTING
//  1 seg_n=~7'h5B held 20 clk, ready=1 -> valid pulses once at clk STABLE_CYCLES+2, digit=2, history[3:0]=2, count=1.
//  2 seg_n=~7'h06 held, ready=0 for 10 clk then 1; seg_n changes to ~7'h4F meanwhile -> digit stays 1 until accept,
//    then after STABLE_CYCLES+? clocks, 3 reported; history[7:0]=8'h13.
//  3 seg_n toggles ~7'h3F/~7'h06 every 5 clk for 100 clk -> valid never asserts.
//  4 seg_n=~7'h55 stable -> valid=1, invalid=1, digit=0; after accept, count and history unchanged.
//  5 seg_n=~7'h6F stable -> digit=9,invalid=0 with SEG7_ALT_GLYPH_EN; invalid=1 without.
//  6 17 distinct valid digits accepted -> count=15 (saturated), history holds last DEPTH digits;
//    assert RESET_N=0 while valid=1 -> valid, count, history all 0 asynchronously.

Source files
------------

// File: rtl/seg7_pattern_decoder.sv
// Decodes a debounced active-low 7-segment bus back to hex digits with handshake and history.
// Define SEG7_ALT_GLYPH_EN to also accept the alternate 9 (6F) and 7 (27) glyphs.
module seg7_pattern_decoder #(
    parameter int STABLE_CYCLES = 16,
    parameter int DEPTH         = 8
) (
    input  logic               CLOCK_50,
    input  logic               RESET_N,
    input  logic [6:0]         seg_n,
    input  logic               sample_en,
    input  logic               ready,
    output logic               valid,
    output logic [3:0]         digit,
    output logic               invalid,
    output logic [4*DEPTH-1:0] history,
    output logic [3:0]         count
);

    localparam int CW = $clog2(STABLE_CYCLES + 1);

    typedef enum logic [1:0] {
        IDLE,
        SETTLE,
        PRESENT,
        HOLD
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [6:0]         r_sync1;
    logic [6:0]         r_sync2;
    logic [6:0]         r_prev;
    logic [6:0]         r_rep;
    logic [6:0]         w_p;
    logic [CW-1:0]      r_stab;
    logic [CW-1:0]      w_stab_nxt;
    logic               w_stable;
    logic               w_load;
    logic               w_xfer;
    logic [3:0]         w_dec_digit;
    logic               w_dec_inv;
    logic               r_valid;
    logic [3:0]         r_digit;
    logic               r_invalid;
    logic [4*DEPTH-1:0] r_hist;
    logic [4*DEPTH-1:0] w_hist_nxt;
    logic [3:0]         r_count;

    assign w_p    = ~r_sync2;
    assign w_xfer = r_valid && ready;

    // Counter value including the current sample; capped so it never wraps.
    always_comb begin
        w_stab_nxt = r_stab;
        if (w_p != r_prev) begin
            w_stab_nxt = CW'(1);
        end else if (r_stab != CW'(STABLE_CYCLES)) begin
            w_stab_nxt = r_stab + CW'(1);
        end
    end

    assign w_stable = (w_stab_nxt == CW'(STABLE_CYCLES));

    always_comb begin
        w_dec_digit = 4'h0;
        w_dec_inv   = 1'b0;
        unique case (w_p)
            7'h3F: w_dec_digit = 4'h0;
            7'h06: w_dec_digit = 4'h1;
            7'h5B: w_dec_digit = 4'h2;
            7'h4F: w_dec_digit = 4'h3;
            7'h66: w_dec_digit = 4'h4;
            7'h6D: w_dec_digit = 4'h5;
            7'h7D: w_dec_digit = 4'h6;
            7'h07: w_dec_digit = 4'h7;
            7'h7F: w_dec_digit = 4'h8;
            7'h67: w_dec_digit = 4'h9;
            7'h77: w_dec_digit = 4'hA;
            7'h7C: w_dec_digit = 4'hB;
            7'h39: w_dec_digit = 4'hC;
            7'h5E: w_dec_digit = 4'hD;
            7'h79: w_dec_digit = 4'hE;
            7'h71: w_dec_digit = 4'hF;
`ifdef SEG7_ALT_GLYPH_EN
            7'h6F: w_dec_digit = 4'h9;
            7'h27: w_dec_digit = 4'h7;
`endif
            default: w_dec_inv = 1'b1;
        endcase
    end

    always_comb begin
        w_state_nxt = r_state;
        w_load      = 1'b0;
        if (!sample_en) begin
            w_state_nxt = IDLE;
        end else begin
            unique case (r_state)
                IDLE: begin
                    if (w_p != 7'h00) w_state_nxt = SETTLE;
                end
                SETTLE: begin
                    if (w_p == 7'h00) begin
                        w_state_nxt = IDLE;
                    end else if (w_stable) begin
                        w_state_nxt = PRESENT;
                        w_load      = 1'b1;
                    end
                end
                PRESENT: begin
                    if (w_xfer) w_state_nxt = HOLD;
                end
                HOLD: begin
                    if (w_p != r_rep) begin
                        w_state_nxt = (w_p == 7'h00) ? IDLE : SETTLE;
                    end
                end
            endcase
        end
    end

    generate
        if (DEPTH > 1) begin : g_shift
            assign w_hist_nxt = {r_hist[4*DEPTH-5:0], r_digit};
        end else begin : g_single
            assign w_hist_nxt = r_digit;
        end
    endgenerate

    always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
        if (!RESET_N) begin
            r_sync1   <= 7'h7F;
            r_sync2   <= 7'h7F;
            r_prev    <= 7'h00;
            r_stab    <= '0;
            r_state   <= IDLE;
            r_rep     <= 7'h00;
            r_valid   <= 1'b0;
            r_digit   <= 4'h0;
            r_invalid <= 1'b0;
            r_hist    <= '0;
            r_count   <= 4'h0;
        end else begin
            r_sync1 <= seg_n;
            r_sync2 <= r_sync1;
            r_prev  <= w_p;
            r_stab  <= w_stab_nxt;
            r_state <= w_state_nxt;
            if (!sample_en) begin
                r_valid <= 1'b0;
            end else if (w_load) begin
                r_valid   <= 1'b1;
                r_digit   <= w_dec_digit;
                r_invalid <= w_dec_inv;
                r_rep     <= w_p;
            end else if (w_xfer) begin
                r_valid <= 1'b0;
            end
            // Completed handshakes still land in history even if capture is being disabled.
            if (w_xfer && !r_invalid) begin
                r_hist <= w_hist_nxt;
                if (r_count != 4'hF) r_count <= r_count + 4'h1;
            end
        end
    end

    assign valid   = r_valid;
    assign digit   = r_digit;
    assign invalid = r_invalid;
    assign history = r_hist;
    assign count   = r_count;

endmodule
